// File: rtl/mux_scan_tdm.sv
// Registered N-channel mux with manual select or round-robin TDM scan.
// AUTO dwells DWELL enabled cycles per channel and flags one sample each.
module mux_scan_tdm #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      valid,
    output logic                      frame_start
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             prev_mode;

    logic             entering;
    logic [SEL_W-1:0] eptr;
    logic [CNT_W-1:0] ecnt;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] pick;
    logic             idx_ok;

    // Entering AUTO restarts the scan at ch0 on this very cycle.
    always_comb begin
        entering = mode & ~prev_mode;
        eptr     = entering ? '0 : ptr;
        ecnt     = entering ? '0 : cnt;
        idx      = mode ? eptr : sel_in;
        pick     = '0;
        idx_ok   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                pick   = din[k*WIDTH +: WIDTH];
                idx_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout        <= '0;
            ch_out      <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
            prev_mode   <= 1'b0;
        end else begin
            valid       <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                prev_mode <= mode;
                ch_out    <= idx;
                dout      <= idx_ok ? pick : '0;
                if (!mode) begin
                    valid <= idx_ok;
                    ptr   <= '0;
                    cnt   <= '0;
                end else if (ecnt == CNT_LAST) begin
                    valid       <= 1'b1;
                    frame_start <= (eptr == '0);
                    cnt         <= '0;
                    ptr         <= (eptr == PTR_LAST) ? '0
                                                      : eptr + SEL_W'(1);
                end else begin
                    cnt <= ecnt + CNT_W'(1);
                    ptr <= eptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_tdm.sv
// Directed bench for mux_scan_tdm: manual sweep, illegal select,
// AUTO scan with DWELL=4 and DWELL=1, enable gating, mode/reset aborts.
module tb_mux_scan_tdm;

    logic       clk = 0;
    logic       rst, en, mode;
    logic [1:0] sel_in;
    logic [31:0] din4;
    logic [23:0] din3;

    logic [7:0] dout0, dout1, dout2;
    logic [1:0] ch0, ch1, ch2;
    logic       v0, v1, v2, fs0, fs1, fs2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_scan_tdm #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .din(din4), .dout(dout0), .ch_out(ch0), .valid(v0),
        .frame_start(fs0));

    mux_scan_tdm #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(4)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .din(din3), .dout(dout1), .ch_out(ch1), .valid(v1),
        .frame_start(fs1));

    mux_scan_tdm #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .din(din4), .dout(dout2), .ch_out(ch2), .valid(v2),
        .frame_start(fs2));

    typedef struct {
        logic [1:0] sel;
        logic [7:0] e_dout;
        logic [1:0] e_ch;
        logic       e_valid;
        logic       e_fs;
    } vec_t;

    vec_t tbl[4];
    logic [7:0] chv[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [7:0] d,
                        input logic [1:0] c, input logic v,
                        input logic f);
        chk({tag, ".dout"}, 32'(dout0), 32'(d));
        chk({tag, ".ch"}, 32'(ch0), 32'(c));
        chk({tag, ".valid"}, 32'(v0), 32'(v));
        chk({tag, ".fs"}, 32'(fs0), 32'(f));
    endtask

    initial begin
        chv[0] = 8'hA0; chv[1] = 8'hB1; chv[2] = 8'hC2; chv[3] = 8'hD3;
        tbl[0] = '{2'd0, 8'hA0, 2'd0, 1'b1, 1'b0};
        tbl[1] = '{2'd1, 8'hB1, 2'd1, 1'b1, 1'b0};
        tbl[2] = '{2'd2, 8'hC2, 2'd2, 1'b1, 1'b0};
        tbl[3] = '{2'd3, 8'hD3, 2'd3, 1'b1, 1'b0};

        din4 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        din3 = {8'hC2, 8'hB1, 8'hA0};
        rst = 1; en = 1; mode = 0; sel_in = 2'd2;
        step();
        chk0("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("reset.u2valid", 32'(v2), 32'd0);
        rst = 0;

        // T1 manual sweep
        for (int i = 0; i < 4; i++) begin
            sel_in = tbl[i].sel;
            step();
            chk0($sformatf("t1[%0d]", i), tbl[i].e_dout, tbl[i].e_ch,
                 tbl[i].e_valid, tbl[i].e_fs);
        end

        // T2 illegal select on the 3-channel instance
        sel_in = 2'd3;
        step();
        chk("t2.ill.dout", 32'(dout1), 32'h0);
        chk("t2.ill.valid", 32'(v1), 32'd0);
        chk("t2.ill.ch", 32'(ch1), 32'd3);
        sel_in = 2'd1;
        step();
        chk("t2.ok.dout", 32'(dout1), 32'hB1);
        chk("t2.ok.valid", 32'(v1), 32'd1);
        chk("t2.ok.ch", 32'(ch1), 32'd1);

        // T3 / T6 AUTO scan from reset
        rst = 1;
        step();
        rst = 0; mode = 1;
        for (int c = 1; c <= 20; c++) begin
            int ec, ec2;
            logic ev;
            step();
            ec  = ((c - 1) / 4) % 4;
            ev  = (c % 4) == 0;
            chk0($sformatf("t3[%0d]", c), chv[ec], 2'(ec), ev,
                 ev && ec == 0);
            ec2 = (c - 1) % 4;
            chk($sformatf("t6[%0d].ch", c), 32'(ch2), 32'(ec2));
            chk($sformatf("t6[%0d].valid", c), 32'(v2), 32'd1);
            chk($sformatf("t6[%0d].fs", c), 32'(fs2), 32'(ec2 == 0));
            chk($sformatf("t6[%0d].dout", c), 32'(dout2), 32'(chv[ec2]));
        end

        // T4 enable gating: two enabled cycles into ch1 dwell, then freeze
        step();
        step();
        chk0("t4.pre", 8'hB1, 2'd1, 1'b0, 1'b0);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk0($sformatf("t4.hold%0d", i), 8'hB1, 2'd1, 1'b0, 1'b0);
        end
        en = 1;
        step();
        chk0("t4.en1", 8'hB1, 2'd1, 1'b0, 1'b0);
        step();
        chk0("t4.en2", 8'hB1, 2'd1, 1'b1, 1'b0);

        // T5 leave AUTO mid ch2 dwell, re-enter, then reset mid-scan
        step();
        step();
        chk0("t5.ch2", 8'hC2, 2'd2, 1'b0, 1'b0);
        mode = 0; sel_in = 2'd0;
        step();
        chk0("t5.manual", 8'hA0, 2'd0, 1'b1, 1'b0);
        mode = 1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk0($sformatf("t5.re%0d", i), 8'hA0, 2'd0, i == 4, i == 4);
        end
        step();
        step();
        rst = 1;
        step();
        chk0("t5.rst", 8'h00, 2'd0, 1'b0, 1'b0);
        rst = 0;
        step();
        chk0("t5.after", 8'hA0, 2'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
